inst_fetch_unit: RTL and testbench

Instruction fetch front end for the RISC-V core: owns the program counter, issues word reads to instruction memory over a valid/ready request channel, buffers returned words, and presents `inst` with its `inst_pc` to the instruction decoder/controller under a valid/ready handshake. Taken branches and jumps arrive as a redirect, driven from the controller's `PCSrc` plus the computed target, and flush everything fetched down the old path.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/inst_fetch_unit_if.sv | 28 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/inst_fetch_unit.sv | 74 +++++++
 tb/tb_inst_fetch_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Memory request/response channel, decoder handshake and redirect port of the fetch unit.
interface inst_fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // NOTE: flush outranks push and pop, so nothing written in a flush cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage has no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: PC, credit-limited memory requests, in-order response buffer, redirect flush.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] inflight_addr;
  fetch_entry_t    rsp_entry;
  fetch_entry_t    head;
  logic            req_fire;
  logic            rsp_keep;
  logic            inst_fire;

  assign bus.imem_req_valid = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
  assign bus.imem_req_addr  = pc;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep  = bus.imem_rsp_valid && (drop_cnt == '0);
  assign inst_fire = bus.inst_valid && bus.inst_ready;
  assign rsp_entry = '{pc: inflight_addr, inst: bus.imem_rsp_data};

  // Addresses of requests still waiting for their response, oldest first.
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (bus.imem_rsp_valid),
    .head      (inflight_addr),
    .count     (outstanding)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (rsp_keep),
    .push_data (rsp_entry),
    .pop       (inst_fire),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.inst_valid = (fifo_count != '0);
  assign bus.inst       = bus.inst_valid ? head.inst : NOP_INST;
  assign bus.inst_pc    = bus.inst_valid ? head.pc   : RESET_PC;

  // On redirect every request still in flight after this edge belongs to the old path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      pc       <= word_align(bus.redirect_pc);
      drop_cnt <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      if (bus.imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench: memory model with fixed latency, scoreboard of the architectural fetch stream.
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  localparam int              DEPTH = 4;
  localparam logic [31:0]     RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_acc = 0;
  int          n_fire = 0;
  int          first_acc = -1;
  int          first_fire = -1;
  bit          post_redirect = 0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_req = RST_PC;
  rsp_t        memq[$];
  logic [31:0] fired[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // One clock cycle: drive inputs at the falling edge, score what the rising edge will accept.
  task automatic cycle(input bit rr, input bit ir, input bit rd, input logic [31:0] tgt);
    bit rsp_now, req_fire, inst_fire;
    rsp_now = (memq.size() > 0) && (memq[0].due <= cyc);
    bus.imem_req_ready = rr;
    bus.inst_ready     = ir;
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? mem_word(memq[0].addr) : $urandom;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rd ? tgt : $urandom;
    #1;
    if (post_redirect) check("valid_after_redirect", bus.inst_valid, 0);
    if (!bus.inst_valid) begin
      check("empty_inst", bus.inst, NOP_INST);
      check("empty_inst_pc", bus.inst_pc, RST_PC);
    end
    req_fire  = bus.imem_req_valid && rr;
    inst_fire = bus.inst_valid && ir;
    if (req_fire) begin
      check("req_addr", bus.imem_req_addr, exp_req);
      memq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      exp_req += 32'd4;
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (rsp_now) void'(memq.pop_front());
    check("inflight_bound", memq.size() <= DEPTH, 1);
    if (inst_fire) begin
      check("inst_pc", bus.inst_pc, exp_pc);
      check("inst_word", bus.inst, mem_word(exp_pc));
      fired.push_back(bus.inst_pc);
      exp_pc += 32'd4;
      n_fire++;
      if (first_fire < 0) first_fire = cyc;
    end
    if (rd) begin
      exp_pc  = tgt & ~32'h3;
      exp_req = tgt & ~32'h3;
    end
    post_redirect = rd;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    bus.imem_req_ready = 0;
    bus.inst_ready     = 0;
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 0;
    bus.redirect_pc    = '0;
    rst_n = 0;
    memq.delete();
    post_redirect = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_inst", bus.inst, NOP_INST);
    check("rst_inst_pc", bus.inst_pc, RST_PC);
    rst_n = 1;
    exp_pc = RST_PC;
    exp_req = RST_PC;
    first_acc = -1;
    first_fire = -1;
    fired.delete();
    #1;
    check("rst_req_valid", bus.imem_req_valid, 1);
    check("rst_req_addr", bus.imem_req_addr, RST_PC);
  endtask

  initial begin
    int          n0;
    logic [31:0] pc_at_redirect;
    bit          found;

    // Streaming at latency 1: first word two cycles after first accept, then one per cycle.
    do_reset();
    lat = 1;
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, '0);
    check("first_latency", first_fire - first_acc, 2);
    n0 = n_fire;
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, '0);
    check("throughput", n_fire - n0, 8);
    check("stream_pc0", fired[0], 32'h0);
    check("stream_pc3", fired[3], 32'hc);

    // Decoder stall: exactly DEPTH fetches, then the request channel closes.
    do_reset();
    n0 = n_acc;
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, '0);
    check("stall_fetches", n_acc - n0, DEPTH);
    check("stall_req_valid", bus.imem_req_valid, 0);
    n0 = n_fire;
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, '0);
    check("stall_release", (n_fire - n0) >= DEPTH, 1);

    // Redirect with two responses in flight at latency 3.
    do_reset();
    lat = 3;
    cycle(1, 1, 0, '0);
    cycle(1, 1, 0, '0);
    check("two_outstanding", memq.size(), 2);
    fired.delete();
    cycle(0, 1, 1, 32'h100);
    for (int i = 0; i < 14; i++) cycle(1, 1, 0, '0);
    check("redir_count", fired.size() >= 2, 1);
    if (fired.size() >= 2) begin
      check("redir_pc0", fired[0], 32'h100);
      check("redir_pc1", fired[1], 32'h104);
    end

    // Redirect coinciding with a request accept and an instruction handshake.
    do_reset();
    lat = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.imem_req_valid && bus.inst_valid) found = 1;
      else cycle(1, 1, 0, '0);
    end
    check("found_dual_fire", found, 1);
    pc_at_redirect = exp_pc;
    fired.delete();
    cycle(1, 1, 1, 32'h203);
    check("redir_req_valid", bus.imem_req_valid, 1);
    check("redir_req_addr", bus.imem_req_addr, 32'h200);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, '0);
    check("redir_fires", fired.size() >= 2, 1);
    if (fired.size() >= 2) begin
      check("redir_consumed", fired[0], pc_at_redirect);
      check("redir_new_pc", fired[1], 32'h200);
    end

    // Asynchronous reset mid-stream with one request outstanding.
    do_reset();
    lat = 3;
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, '0);
    for (int i = 0; i < 10 && memq.size() != 1; i++) cycle(0, 1, 0, '0);
    check("ar_one_outstanding", memq.size(), 1);
    #2 rst_n = 0;
    #1;
    check("ar_inst_valid", bus.inst_valid, 0);
    check("ar_inst", bus.inst, NOP_INST);
    check("ar_inst_pc", bus.inst_pc, RST_PC);
    check("ar_req_valid", bus.imem_req_valid, 1);
    check("ar_req_addr", bus.imem_req_addr, RST_PC);
    memq.delete();
    post_redirect = 0;
    @(negedge clk);
    rst_n = 1;
    exp_pc = RST_PC;
    exp_req = RST_PC;
    fired.delete();
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, '0);
    check("ar_restart_count", fired.size() >= 1, 1);
    if (fired.size() >= 1) check("ar_restart_pc", fired[0], RST_PC);

    // Random traffic: varying latency, memory/decoder backpressure, redirects incl. address wrap.
    n0 = n_fire;
    for (int ph = 0; ph < 6; ph++) begin
      lat = 1 + (ph % 3);
      for (int i = 0; i < 150; i++) begin
        logic [31:0] tgt;
        tgt = (ph == 4) ? (32'hffff_fff0 | 32'($urandom_range(0, 15))) : $urandom;
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0, tgt);
      end
      for (int i = 0; i < 8 && memq.size() != 0; i++) cycle(0, 1, 0, '0);
      check("phase_drained", memq.size(), 0);
    end
    check("random_progress", (n_fire - n0) > 150, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
